// File: rtl/grid_pkg.sv
// Shared constants and types for the paper-roll grid loader.
package grid_pkg;

  localparam logic [7:0] CH_ROLL  = 8'h40;  // '@'
  localparam logic [7:0] CH_EMPTY = 8'h2E;  // '.'
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    ERR  = 2'd2
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_BYTE  = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_SHORT = 2'd3
  } loader_err_t;

endpackage

// File: rtl/grid_loader_if.sv
// Byte-stream input and grid handoff signals of the grid loader.
// master: byte producer / grid consumer side; slave: the loader itself.
interface grid_loader_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
);

  localparam int unsigned CntW = $clog2(WIDTH * DEPTH + 1);

  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic [WIDTH*DEPTH-1:0]   grid;
  logic                     grid_valid;
  logic                     grid_ready;
  logic [CntW-1:0]          roll_count;
  logic                     err;
  logic [1:0]               err_code;

  modport master (
    output in_valid, in_data, grid_ready,
    input  in_ready, grid, grid_valid, roll_count, err, err_code
  );

  modport slave (
    input  in_valid, in_data, grid_ready,
    output in_ready, grid, grid_valid, roll_count, err, err_code
  );

endinterface

// File: rtl/grid_loader.sv
// Parses an ASCII '@'/'.'/LF stream into a WIDTH x DEPTH bit grid and hands it
// off with valid/ready. Malformed input parks the loader in a sticky error state.
// Optional feature: define GRID_LOADER_POPCOUNT_EN to build the roll counter;
// otherwise roll_count is tied to 0.
module grid_loader
  import grid_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  grid_loader_if.slave bus
);

  localparam int unsigned RowW = $clog2(DEPTH + 1);
  localparam int unsigned ColW = $clog2(WIDTH + 1);
  localparam int unsigned CntW = $clog2(WIDTH * DEPTH + 1);

  loader_state_t          state_q, state_d;
  loader_err_t            err_code_q, err_code_d;
  logic [WIDTH*DEPTH-1:0] grid_q, grid_d;
  logic [RowW-1:0]        row_q, row_d;
  logic [ColW-1:0]        col_q, col_d;
`ifdef GRID_LOADER_POPCOUNT_EN
  logic [CntW-1:0]        cnt_q, cnt_d;
`endif

  logic accept;
  logic col_full;

  // In ERR bytes are still accepted so the upstream never stalls; they are dropped.
  assign accept   = bus.in_valid && (state_q != HOLD);
  assign col_full = (col_q == ColW'(WIDTH));

  // Next-state: byte decode, indexed bit write, handoff clear.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    grid_d     = grid_q;
    row_d      = row_q;
    col_d      = col_q;
`ifdef GRID_LOADER_POPCOUNT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (bus.in_data == CH_ROLL || bus.in_data == CH_EMPTY) begin
            if (col_full) begin
              state_d    = ERR;
              err_code_d = ERR_LONG;
            end else begin
              for (int r = 0; r < int'(DEPTH); r++) begin
                for (int c = 0; c < int'(WIDTH); c++) begin
                  if (row_q == RowW'(r) && col_q == ColW'(c)) begin
                    grid_d[r*int'(WIDTH)+c] = (bus.in_data == CH_ROLL);
                  end
                end
              end
              col_d = col_q + ColW'(1);
`ifdef GRID_LOADER_POPCOUNT_EN
              if (bus.in_data == CH_ROLL) cnt_d = cnt_q + CntW'(1);
`endif
            end
          end else if (bus.in_data == CH_LF) begin
            if (col_full) begin
              col_d = '0;
              row_d = row_q + RowW'(1);
              if (row_q == RowW'(DEPTH - 1)) state_d = HOLD;
            end else begin
              state_d    = ERR;
              err_code_d = ERR_SHORT;
            end
          end else if (bus.in_data != CH_CR) begin
            state_d    = ERR;
            err_code_d = ERR_BYTE;
          end
        end
      end
      HOLD: begin
        if (bus.grid_ready) begin
          state_d = LOAD;
          grid_d  = '0;
          row_d   = '0;
          col_d   = '0;
`ifdef GRID_LOADER_POPCOUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: ;  // ERR: only rst leaves
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      err_code_q <= ERR_NONE;
      grid_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
`ifdef GRID_LOADER_POPCOUNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      grid_q     <= grid_d;
      row_q      <= row_d;
      col_q      <= col_d;
`ifdef GRID_LOADER_POPCOUNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q != HOLD);
  assign bus.grid_valid = (state_q == HOLD);
  assign bus.grid       = grid_q;
  assign bus.err        = (state_q == ERR);
  assign bus.err_code   = err_code_q;
`ifdef GRID_LOADER_POPCOUNT_EN
  assign bus.roll_count = cnt_q;
`else
  assign bus.roll_count = '0;
`endif

endmodule

// File: tb/tb_grid_loader.sv
// Directed self-checking bench for grid_loader at WIDTH=4, DEPTH=3.
module tb_grid_loader;

  localparam int unsigned W = 4;
  localparam int unsigned D = 3;

  logic clk = 1'b0;
  logic rst;

  grid_loader_if #(.WIDTH(W), .DEPTH(D)) bus ();

  grid_loader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef GRID_LOADER_POPCOUNT_EN
    return 32'(n);
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Present one byte for one cycle; returns on the following negedge.
  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send(s[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_grid"}, 32'(bus.grid), 32'h0);
    chk({tag, "_valid"}, 32'(bus.grid_valid), 32'h0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'h1);
    chk({tag, "_cnt"}, 32'(bus.roll_count), 32'h0);
  endtask

  task automatic handoff();
    bus.grid_ready = 1'b1;
    @(negedge clk);
    bus.grid_ready = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.grid_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_cleared("rst");
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_code", 32'(bus.err_code), 32'h0);

    // Frame 1, no gaps
    send("@");
    chk("f1_first_bit", 32'(bus.grid), 32'h001);
    send_str(".@@\n....\n@@@@", 1'b0);
    chk("f1_pre_lf_valid", 32'(bus.grid_valid), 32'h0);
    chk("f1_pre_lf_ready", 32'(bus.in_ready), 32'h1);
    send(8'h0A);
    chk("f1_valid", 32'(bus.grid_valid), 32'h1);
    chk("f1_grid", 32'(bus.grid), 32'hF0D);
    chk("f1_cnt", 32'(bus.roll_count), exp_cnt(7));
    chk("f1_ready_held", 32'(bus.in_ready), 32'h0);

    // Held for 10 cycles, with a stray byte offered that must not be taken
    bus.in_valid = 1'b1;
    bus.in_data  = "x";
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("hold_valid", 32'(bus.grid_valid), 32'h1);
    chk("hold_grid", 32'(bus.grid), 32'hF0D);
    chk("hold_err", 32'(bus.err), 32'h0);
    handoff();
    check_cleared("handoff1");

    // Frame 2
    send_str("....\n....\n...@\n", 1'b0);
    chk("f2_valid", 32'(bus.grid_valid), 32'h1);
    chk("f2_grid", 32'(bus.grid), 32'h800);
    chk("f2_cnt", 32'(bus.roll_count), exp_cnt(1));
    handoff();
    check_cleared("handoff2");

    // Frame with CR before each LF and random valid gaps
    send_str("@.@@\015\n....\015\n@@@@\015\n", 1'b1);
    chk("cr_valid", 32'(bus.grid_valid), 32'h1);
    chk("cr_grid", 32'(bus.grid), 32'hF0D);
    chk("cr_err", 32'(bus.err), 32'h0);
    chk("cr_cnt", 32'(bus.roll_count), exp_cnt(7));
    handoff();

    // Row too long
    send_str("@@@@", 1'b0);
    chk("long_pre_err", 32'(bus.err), 32'h0);
    send("@");
    chk("long_err", 32'(bus.err), 32'h1);
    chk("long_code", 32'(bus.err_code), 32'h2);
    send_str("\n@@@@\n....\n@@@@\n", 1'b0);
    chk("long_ready", 32'(bus.in_ready), 32'h1);
    chk("long_valid", 32'(bus.grid_valid), 32'h0);
    chk("long_code_kept", 32'(bus.err_code), 32'h2);
    do_reset();
    check_cleared("long_rst");
    chk("long_rst_err", 32'(bus.err), 32'h0);

    // Row too short
    send_str("@@\n", 1'b0);
    chk("short_err", 32'(bus.err), 32'h1);
    chk("short_code", 32'(bus.err_code), 32'h3);
    do_reset();

    // Empty first line
    send("\n");
    chk("empty_code", 32'(bus.err_code), 32'h3);
    do_reset();

    // Illegal byte, then a would-be second error
    send("@");
    send("x");
    chk("byte_err", 32'(bus.err), 32'h1);
    chk("byte_code", 32'(bus.err_code), 32'h1);
    send("\n");
    chk("byte_code_kept", 32'(bus.err_code), 32'h1);
    do_reset();

    // Reset mid row 2, then a full frame
    send_str("@@@@\n....\n@@", 1'b0);
    do_reset();
    check_cleared("mid_rst");
    chk("mid_rst_err", 32'(bus.err), 32'h0);
    chk("mid_rst_code", 32'(bus.err_code), 32'h0);
    send_str("@.@@\n....\n@@@@\n", 1'b0);
    chk("after_rst_valid", 32'(bus.grid_valid), 32'h1);
    chk("after_rst_grid", 32'(bus.grid), 32'hF0D);
    chk("after_rst_cnt", 32'(bus.roll_count), exp_cnt(7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
